// File: rtl/uart_cmd_frame_parser_if.sv
// Byte stream in from the UART receiver, decoded command and response byte out.
// master = byte source / response sink side, slave = the frame parser.
interface uart_cmd_frame_parser_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [3:0] ctrl_command;
   logic [3:0] value_command;
   logic       command_out_flag;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] err_cnt;
   logic       parser_busy;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  ctrl_command, value_command, command_out_flag,
      input  tx_data, tx_valid, err_cnt, parser_busy
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output ctrl_command, value_command, command_out_flag,
      output tx_data, tx_valid, err_cnt, parser_busy
   );
endinterface

// File: rtl/uart_cmd_frame_parser.sv
// Assembles 5-byte command frames (HDR0 HDR1 CMD VAL CHK), validates them and
// publishes the decoded command plus a single-entry ACK/NAK response.
module uart_cmd_frame_parser #(
   parameter logic [7:0] HDR0           = 8'h55,
   parameter logic [7:0] HDR1           = 8'hAA,
   parameter logic [7:0] ACK_BYTE       = 8'h06,
   parameter logic [7:0] NAK_BYTE       = 8'h15,
   parameter int         TIMEOUT_CYCLES = 500000
) (
   input logic                     sys_clk,
   input logic                     sys_rst,
   uart_cmd_frame_parser_if.slave  bus
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR2    = 3'd1,
      GET_CMD = 3'd2,
      GET_VAL = 3'd3,
      GET_CHK = 3'd4
   } state_t;

   state_t        state_reg, state_next;
   logic [TW-1:0] to_cnt_reg;
   logic [7:0]    cmd_reg, val_reg;
   logic [3:0]    ctrl_reg, value_reg;
   logic          flag_reg;
   logic [7:0]    tx_data_reg;
   logic          tx_valid_reg;
   logic [7:0]    err_reg;

   logic          busy_w;
   logic          timeout_hit;
   logic          frame_done;
   logic          frame_good;
   logic          frame_bad;
   logic [7:0]    chk_sum;
   logic          chk_ok;
   logic          fmt_ok;
   logic          resp_load;
   logic [7:0]    resp_byte;

   assign chk_sum = cmd_reg + val_reg;
   assign chk_ok  = (bus.rx_data == chk_sum);
   assign fmt_ok  = (cmd_reg[7:4] == 4'h0) && (val_reg[7:4] == 4'h0);

   // ---- state register ----
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_next = state_reg;
      if (timeout_hit) begin
         state_next = IDLE;
      end else if (bus.rx_valid) begin
         case (state_reg)
            IDLE:    if (bus.rx_data == HDR0) state_next = HDR2;
            HDR2: begin
               // A repeated HDR0 is treated as a fresh start of frame.
               if (bus.rx_data == HDR1)      state_next = GET_CMD;
               else if (bus.rx_data != HDR0) state_next = IDLE;
            end
            GET_CMD: state_next = GET_VAL;
            GET_VAL: state_next = GET_CHK;
            GET_CHK: state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // ---- output / decision logic ----
   always_comb begin
      busy_w      = (state_reg != IDLE);
      // An arriving byte takes priority over an expiring timeout.
      timeout_hit = busy_w && !bus.rx_valid && (to_cnt_reg == TO_LAST);
      frame_done  = (state_reg == GET_CHK) && bus.rx_valid;
      frame_good  = frame_done && chk_ok && fmt_ok;
      frame_bad   = frame_done && !(chk_ok && fmt_ok);
      resp_load   = frame_done || timeout_hit;
      resp_byte   = frame_good ? ACK_BYTE : NAK_BYTE;
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         to_cnt_reg   <= '0;
         cmd_reg      <= 8'h00;
         val_reg      <= 8'h00;
         ctrl_reg     <= 4'h0;
         value_reg    <= 4'h0;
         flag_reg     <= 1'b0;
         tx_data_reg  <= 8'h00;
         tx_valid_reg <= 1'b0;
         err_reg      <= 8'h00;
      end else begin
         if (!busy_w || bus.rx_valid || timeout_hit) begin
            to_cnt_reg <= '0;
         end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
         end

         if (state_reg == GET_CMD && bus.rx_valid) cmd_reg <= bus.rx_data;
         if (state_reg == GET_VAL && bus.rx_valid) val_reg <= bus.rx_data;

         flag_reg <= frame_good;
         if (frame_good) begin
            ctrl_reg  <= cmd_reg[3:0];
            value_reg <= val_reg[3:0];
         end

         if ((frame_bad || timeout_hit) && err_reg != 8'hFF) begin
            err_reg <= err_reg + 8'd1;
         end

         // Single-entry queue: a pending byte blocks new ones unless it is
         // being accepted this very cycle.
         if (resp_load && (!tx_valid_reg || bus.tx_ready)) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= resp_byte;
         end else if (tx_valid_reg && bus.tx_ready) begin
            tx_valid_reg <= 1'b0;
         end
      end
   end

   assign bus.ctrl_command     = ctrl_reg;
   assign bus.value_command    = value_reg;
   assign bus.command_out_flag = flag_reg;
   assign bus.tx_data          = tx_data_reg;
   assign bus.tx_valid         = tx_valid_reg;
   assign bus.err_cnt          = err_reg;
   assign bus.parser_busy      = busy_w;

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Table vectors, hand-written corner sequences and randomized frames, all
// checked every cycle against a queue-based frame model.
module tb_uart_cmd_frame_parser;

   localparam int TO = 100;

   logic sys_clk;
   logic sys_rst;

   uart_cmd_frame_parser_if bus ();

   uart_cmd_frame_parser #(
      .HDR0(8'h55), .HDR1(8'hAA), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_bad = 0;

   // ---- reference model state ----
   logic [7:0] m_buf[$];
   int         m_gap;
   logic [3:0] m_ctrl, m_val;
   logic       m_flag;
   logic       m_txv;
   logic [7:0] m_txd;
   int         m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_buf.delete();
      m_gap = 0; m_ctrl = 4'h0; m_val = 4'h0; m_flag = 1'b0;
      m_txv = 1'b0; m_txd = 8'h00; m_err = 0;
   endtask

   // One clock of the frame rules, expressed on a byte buffer.
   task automatic model_update(input logic v, input logic [7:0] d, input logic rdy);
      int resp;
      int c, x;
      resp   = -1;
      m_flag = 1'b0;
      if (v) begin
         m_gap = 0;
         case (m_buf.size())
            0: if (d == 8'h55) m_buf.push_back(d);
            1: begin
               if (d == 8'hAA) m_buf.push_back(d);
               else if (d != 8'h55) m_buf.delete();
            end
            2, 3: m_buf.push_back(d);
            default: begin
               c = int'(m_buf[2]);
               x = int'(m_buf[3]);
               if (c < 16 && x < 16 && ((c + x) % 256) == int'(d)) begin
                  m_ctrl = 4'(c); m_val = 4'(x); m_flag = 1'b1; resp = 8'h06;
               end else begin
                  if (m_err < 255) m_err++;
                  resp = 8'h15;
               end
               m_buf.delete();
            end
         endcase
      end else if (m_buf.size() > 0) begin
         m_gap++;
         if (m_gap == TO) begin
            m_buf.delete();
            m_gap = 0;
            if (m_err < 255) m_err++;
            resp = 8'h15;
         end
      end
      if (resp >= 0 && (!m_txv || rdy)) begin
         m_txv = 1'b1; m_txd = 8'(resp);
      end else if (m_txv && rdy) begin
         m_txv = 1'b0;
      end
   endtask

   task automatic check_all();
      chk("m_ctrl",     32'(bus.ctrl_command),     32'(m_ctrl));
      chk("m_value",    32'(bus.value_command),    32'(m_val));
      chk("m_flag",     32'(bus.command_out_flag), 32'(m_flag));
      chk("m_tx_valid", 32'(bus.tx_valid),         32'(m_txv));
      chk("m_tx_data",  32'(bus.tx_data),          32'(m_txd));
      chk("m_err_cnt",  32'(bus.err_cnt),          32'(m_err));
      chk("m_busy",     32'(bus.parser_busy),      32'(m_buf.size() > 0));
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic rdy);
      bus.rx_valid = v; bus.rx_data = d; bus.tx_ready = rdy;
      @(posedge sys_clk);
      model_update(v, d, rdy);
      #1;
      check_all();
   endtask

   task automatic send_frame(input logic [39:0] f, input logic rdy);
      for (int i = 0; i < 5; i++) step(1'b1, f[8*(4-i) +: 8], rdy);
   endtask

   task automatic do_reset();
      bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
      sys_rst = 1'b0;
      #2;
      chk("rst_ctrl",  32'(bus.ctrl_command),     0);
      chk("rst_value", 32'(bus.value_command),    0);
      chk("rst_flag",  32'(bus.command_out_flag), 0);
      chk("rst_txv",   32'(bus.tx_valid),         0);
      chk("rst_txd",   32'(bus.tx_data),          0);
      chk("rst_err",   32'(bus.err_cnt),          0);
      chk("rst_busy",  32'(bus.parser_busy),      0);
      model_reset();
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst = 1'b1;
   endtask

   function automatic logic rnd_ready();
      return ($urandom_range(0, 3) != 0);
   endfunction

   typedef struct {
      string      name;
      int         n;
      logic [63:0] bytes;
      logic [3:0] ctrl;
      logic [3:0] val;
      logic       flag;
      logic [7:0] tx;
      logic [7:0] err;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vec_t       tv;
      logic [7:0] c8, v8, k8;
      logic [7:0] fb[$];
      int         kind, cut;

      vecs[0]  = '{"ack_basic",   5, 64'h55AA020103,     4'h2, 4'h1, 1'b1, 8'h06, 8'd0};
      vecs[1]  = '{"bad_chk",     5, 64'h55AA020104,     4'h2, 4'h1, 1'b0, 8'h15, 8'd1};
      vecs[2]  = '{"bad_fmt_cmd", 5, 64'h55AA120113,     4'h2, 4'h1, 1'b0, 8'h15, 8'd2};
      vecs[3]  = '{"preamble",    6, 64'h5555AA090009,   4'h9, 4'h0, 1'b1, 8'h06, 8'd2};
      vecs[4]  = '{"max_nibbles", 5, 64'h55AA0F0F1E,     4'hF, 4'hF, 1'b1, 8'h06, 8'd2};
      vecs[5]  = '{"bad_fmt_val", 5, 64'h55AA03F0F3,     4'hF, 4'hF, 1'b0, 8'h15, 8'd3};
      vecs[6]  = '{"junk_lead",   6, 64'h0055AA010203,   4'h1, 4'h2, 1'b1, 8'h06, 8'd3};
      vecs[7]  = '{"all_zero",    5, 64'h55AA000000,     4'h0, 4'h0, 1'b1, 8'h06, 8'd3};
      vecs[8]  = '{"fmt_wrap",    5, 64'h55AAFF0100,     4'h0, 4'h0, 1'b0, 8'h15, 8'd4};
      vecs[9]  = '{"hdr_abort",   7, 64'h551155AA050A0F, 4'h5, 4'hA, 1'b1, 8'h06, 8'd4};
      vecs[10] = '{"chk_wrap",    5, 64'h55AA808000,     4'h5, 4'hA, 1'b0, 8'h15, 8'd5};
      vecs[11] = '{"aa_lead",     6, 64'hAA55AA07030A,   4'h7, 4'h3, 1'b1, 8'h06, 8'd5};

      sys_rst = 1'b0;
      bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
      do_reset();

      // ---- table-driven frames ----
      for (int k = 0; k < 12; k++) begin
         tv = vecs[k];
         for (int i = 0; i < tv.n; i++) step(1'b1, tv.bytes[8*(tv.n-1-i) +: 8], 1'b1);
         chk($sformatf("%s_ctrl", tv.name),  32'(bus.ctrl_command),     32'(tv.ctrl));
         chk($sformatf("%s_value", tv.name), 32'(bus.value_command),    32'(tv.val));
         chk($sformatf("%s_flag", tv.name),  32'(bus.command_out_flag), 32'(tv.flag));
         chk($sformatf("%s_txv", tv.name),   32'(bus.tx_valid),         1);
         chk($sformatf("%s_txd", tv.name),   32'(bus.tx_data),          32'(tv.tx));
         chk($sformatf("%s_err", tv.name),   32'(bus.err_cnt),          32'(tv.err));
         step(1'b0, 8'h00, 1'b1);
         chk($sformatf("%s_flag_clr", tv.name), 32'(bus.command_out_flag), 0);
         chk($sformatf("%s_txv_clr", tv.name),  32'(bus.tx_valid),         0);
      end

      // ---- timeout after CMD byte ----
      step(1'b1, 8'h55, 1'b1); step(1'b1, 8'hAA, 1'b1); step(1'b1, 8'h09, 1'b1);
      repeat (TO - 1) step(1'b0, 8'h00, 1'b0);
      chk("to_busy_before", 32'(bus.parser_busy), 1);
      chk("to_txv_before",  32'(bus.tx_valid),    0);
      step(1'b0, 8'h00, 1'b0);
      chk("to_busy_after", 32'(bus.parser_busy), 0);
      chk("to_txv",        32'(bus.tx_valid),    1);
      chk("to_txd",        32'(bus.tx_data),     32'h15);
      chk("to_err",        32'(bus.err_cnt),     6);
      step(1'b0, 8'h00, 1'b1);

      // ---- byte on the expiring cycle wins ----
      step(1'b1, 8'h55, 1'b1); step(1'b1, 8'hAA, 1'b1); step(1'b1, 8'h09, 1'b1);
      repeat (TO - 1) step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h00, 1'b1);
      chk("race_busy", 32'(bus.parser_busy), 1);
      chk("race_err",  32'(bus.err_cnt),     6);
      step(1'b1, 8'h09, 1'b1);
      chk("race_flag", 32'(bus.command_out_flag), 1);
      chk("race_ctrl", 32'(bus.ctrl_command),     9);
      step(1'b0, 8'h00, 1'b1);

      // ---- back-to-back frames with a stalled transmitter ----
      send_frame(40'h55AA030407, 1'b0);
      send_frame(40'h55AA05060B, 1'b0);
      chk("b2b_ctrl",  32'(bus.ctrl_command),     5);
      chk("b2b_value", 32'(bus.value_command),    6);
      chk("b2b_flag",  32'(bus.command_out_flag), 1);
      chk("b2b_txv",   32'(bus.tx_valid),         1);
      chk("b2b_txd",   32'(bus.tx_data),          32'h06);
      step(1'b0, 8'h00, 1'b1);
      chk("b2b_drain", 32'(bus.tx_valid), 0);
      send_frame(40'h55AA010105, 1'b0);
      send_frame(40'h55AA010102, 1'b0);
      chk("keep_txd",  32'(bus.tx_data),      32'h15);
      chk("keep_ctrl", 32'(bus.ctrl_command), 1);
      chk("keep_err",  32'(bus.err_cnt),      7);
      // Pending NAK accepted on the same cycle a new ACK is produced.
      for (int i = 0; i < 4; i++) step(1'b1, 8'(40'h55AA020204 >> (8*(4-i))), 1'b0);
      step(1'b1, 8'h04, 1'b1);
      chk("swap_txv", 32'(bus.tx_valid), 1);
      chk("swap_txd", 32'(bus.tx_data),  32'h06);
      step(1'b0, 8'h00, 1'b1);

      // ---- reset in the middle of a frame ----
      step(1'b1, 8'h55, 1'b1); step(1'b1, 8'hAA, 1'b1); step(1'b1, 8'h07, 1'b1);
      do_reset();
      send_frame(40'h55AA0B040F, 1'b1);
      chk("post_rst_ctrl",  32'(bus.ctrl_command),     32'hB);
      chk("post_rst_value", 32'(bus.value_command),    4);
      chk("post_rst_flag",  32'(bus.command_out_flag), 1);
      chk("post_rst_txd",   32'(bus.tx_data),          32'h06);
      step(1'b0, 8'h00, 1'b1);

      // ---- error counter saturation ----
      for (int k = 0; k < 260; k++) begin
         send_frame(40'h55AA010100, 1'b1);
         if (k == 253) chk("sat_fe", 32'(bus.err_cnt), 32'hFE);
         if (k == 254) chk("sat_ff", 32'(bus.err_cnt), 32'hFF);
      end
      chk("sat_hold", 32'(bus.err_cnt), 32'hFF);

      // ---- randomized frames against the model ----
      do_reset();
      for (int f = 0; f < 150; f++) begin
         kind = $urandom_range(0, 9);
         c8 = {4'h0, 4'($urandom_range(0, 15))};
         v8 = {4'h0, 4'($urandom_range(0, 15))};
         if (kind == 1) c8[7:4] = 4'($urandom_range(1, 15));
         k8 = c8 + v8;
         if (kind == 0) k8 = k8 + 8'($urandom_range(1, 255));
         fb.delete();
         if (kind == 3) repeat ($urandom_range(1, 3)) fb.push_back(8'($urandom_range(0, 255)));
         fb.push_back(8'h55);
         if (kind == 4) fb.push_back(8'h55);
         fb.push_back(8'hAA); fb.push_back(c8); fb.push_back(v8); fb.push_back(k8);
         if (kind == 2) begin
            cut = $urandom_range(1, 4);
            while (fb.size() > cut) void'(fb.pop_back());
         end
         for (int i = 0; i < fb.size(); i++) begin
            if (kind == 5 && i == fb.size() - 2) begin
               repeat ($urandom_range(TO - 2, TO + 1)) step(1'b0, 8'h00, rnd_ready());
            end else begin
               repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, rnd_ready());
            end
            step(1'b1, fb[i], rnd_ready());
         end
         if (kind == 2) repeat (TO + 2) step(1'b0, 8'h00, rnd_ready());
         else repeat ($urandom_range(0, 3)) step(1'b0, 8'h00, rnd_ready());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
